// File: rtl/latch_cond_pkg.sv
// latch_cond_pkg: shared FSM encoding, default parameters and width helper
// for the latch input conditioner.
package latch_cond_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        PULSE    = 3'd2,
        HOLD     = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    localparam int DEF_DEB_CYCLES = 4;
    localparam int DEF_PULSE_W    = 3;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// debounce_sync: two-flop synchronizer followed by a debouncer that accepts a
// new level only after it has been stable for DEB_CYCLES synchronized cycles.
module debounce_sync
    import latch_cond_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_db
);

    localparam int CW = cnt_width(DEB_CYCLES);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_db;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_db   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (r_sync[1] == r_db)
                r_cnt <= '0;
            else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                r_db  <= r_sync[1];
                r_cnt <= '0;
            end else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/latch_input_conditioner.sv
// latch_input_conditioner: conditions raw d/e pins for the downstream D latch,
// either as one fixed-width enable strobe per press or as a registered pass-through.
module latch_input_conditioner
    import latch_cond_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int PULSE_W    = DEF_PULSE_W,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_raw,
    input  logic             e_raw,
    input  logic             mode_transparent,
    output logic             d_out,
    output logic             e_out,
    output logic             busy,
    output logic [CNT_W-1:0] strobe_count
);

    localparam int PCW = cnt_width(PULSE_W);

    state_t           r_state, w_next;
    logic [PCW-1:0]   r_pcnt, w_pcnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_d_out, r_e_out, r_e_db_q;
    logic             w_d_nxt, w_e_nxt, w_d_db, w_e_db, w_e_rise;

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_deb_d (
        .clk  (clk),
        .rst  (rst),
        .i_raw(d_raw),
        .o_db (w_d_db)
    );

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_deb_e (
        .clk  (clk),
        .rst  (rst),
        .i_raw(e_raw),
        .o_db (w_e_db)
    );

    assign w_e_rise = w_e_db & ~r_e_db_q;

    // Outputs are computed for the next state so e_out/d_out come straight from flops.
    always_comb begin
        w_next  = r_state;
        w_pcnt  = '0;
        w_d_nxt = r_d_out;
        w_e_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (mode_transparent) begin
                    w_d_nxt = w_d_db;
                    w_e_nxt = w_e_db;
                end else if (w_e_rise) begin
                    w_d_nxt = w_d_db;
                    w_next  = SETUP;
                end
            end
            SETUP: begin
                w_next  = PULSE;
                w_e_nxt = 1'b1;
            end
            PULSE: begin
                if (r_pcnt == PCW'(PULSE_W - 1))
                    w_next = HOLD;
                else begin
                    w_pcnt  = r_pcnt + 1'b1;
                    w_e_nxt = 1'b1;
                end
            end
            HOLD:     w_next = w_e_db ? WAIT_REL : IDLE;
            WAIT_REL: w_next = w_e_db ? WAIT_REL : IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_pcnt   <= '0;
            r_d_out  <= 1'b0;
            r_e_out  <= 1'b0;
            r_e_db_q <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_next;
            r_pcnt   <= w_pcnt;
            r_d_out  <= w_d_nxt;
            r_e_out  <= w_e_nxt;
            r_e_db_q <= w_e_db;
            if (r_state == SETUP && r_cnt != '1)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign d_out        = r_d_out;
    assign e_out        = r_e_out;
    assign busy         = (r_state != IDLE);
    assign strobe_count = r_cnt;

endmodule

// File: tb/tb_latch_input_conditioner.sv
// tb_latch_input_conditioner: directed stimulus with a pulse scoreboard; a
// monitor pops the expected capture for every strobe the DUT emits.
module tb_latch_input_conditioner;

    localparam int PW = 3;

    typedef struct {
        logic       d;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, d_raw, e_raw, mode_transparent;
    logic       d_out, e_out, busy;
    logic [7:0] strobe_count;

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t q[$];

    latch_input_conditioner #(.DEB_CYCLES(4), .PULSE_W(PW), .CNT_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .d_raw           (d_raw),
        .e_raw           (e_raw),
        .mode_transparent(mode_transparent),
        .d_out           (d_out),
        .e_out           (e_out),
        .busy            (busy),
        .strobe_count    (strobe_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        chk("idle_bound", busy, 0);
    endtask

    task automatic press_release();
        e_raw = 1'b1;
        repeat (8) step();
        e_raw = 1'b0;
        repeat (8) step();
        wait_idle();
    endtask

    // Monitor: a strobe is e_out rising while busy; check capture, count, stability, width.
    logic in_p = 1'b0;
    int   width = 0;
    exp_t cur;
    always @(negedge clk) begin
        if (rst)
            in_p = 1'b0;
        else if (!in_p && e_out && busy) begin
            in_p  = 1'b1;
            width = 1;
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL extra_pulse: got unexpected strobe, required none at %0t", $time);
                cur = '{d_out, strobe_count};
            end else begin
                cur = q.pop_front();
                chk("sb_count", strobe_count, cur.cnt);
            end
            chk("sb_d", d_out, cur.d);
        end else if (in_p && e_out) begin
            width++;
            chk("sb_d_hold", d_out, cur.d);
        end else if (in_p) begin
            in_p = 1'b0;
            chk("sb_width", width, PW);
            chk("sb_d_after", d_out, cur.d);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; d_raw = 1'b0; e_raw = 1'b0; mode_transparent = 1'b0;
        repeat (3) step();
        chk("rst_e_out", e_out, 0);
        chk("rst_d_out", d_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", strobe_count, 0);

        // 3-cycle glitch on e_raw must be rejected
        rst = 1'b0;
        e_raw = 1'b1;
        repeat (3) step();
        e_raw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("glitch_e_out", e_out, 0);
            chk("glitch_busy", busy, 0);
        end
        chk("glitch_count", strobe_count, 0);

        // first press from reset, d_raw toggling during the pulse
        rst = 1'b1;
        step();
        rst = 1'b0; d_raw = 1'b1; e_raw = 1'b1;
        q.push_back('{1'b1, 8'd1});
        for (int k = 1; k <= 14; k++) begin
            step();
            chk("p1_e_out", e_out, (k >= 8 && k <= 10));
            chk("p1_busy", busy, (k >= 7));
            chk("p1_d_out", d_out, (k >= 7));
            chk("p1_count", strobe_count, (k >= 8));
            if (k >= 7 && k <= 11) d_raw = ~d_raw;
            else if (k == 12) d_raw = 1'b1;
        end
        e_raw = 1'b0;
        for (int k = 15; k <= 21; k++) begin
            step();
            chk("p1_release_busy", busy, (k < 21));
        end

        // second press with d=0 and e_raw bouncing during the pulse
        d_raw = 1'b0;
        repeat (8) step();
        q.push_back('{1'b0, 8'd2});
        e_raw = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            step();
            chk("p2_e_out", e_out, (j >= 8 && j <= 10));
            chk("p2_count", strobe_count, (j >= 8) ? 2 : 1);
            if (j == 8 || j == 10) e_raw = 1'b0;
            else if (j == 9 || j == 11) e_raw = 1'b1;
        end
        e_raw = 1'b0;
        repeat (8) step();
        wait_idle();
        chk("p2_total", strobe_count, 2);

        // transparent mode follows debounced levels one cycle later
        mode_transparent = 1'b1;
        step();
        d_raw = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            step();
            chk("tr_d_out", d_out, (j >= 7));
            chk("tr_busy", busy, 0);
        end
        e_raw = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            step();
            chk("tr_e_out", e_out, (j >= 7));
            chk("tr_busy", busy, 0);
        end
        mode_transparent = 1'b0;
        step();
        chk("tr_exit_e_out", e_out, 0);
        chk("tr_exit_busy", busy, 0);
        e_raw = 1'b0;
        repeat (8) step();

        // transparent requested mid-pulse only applies once back in IDLE
        q.push_back('{1'b1, 8'd3});
        e_raw = 1'b1;
        for (int j = 1; j <= 21; j++) begin
            step();
            if (j >= 8 && j <= 12) begin
                chk("mid_e_out", e_out, (j <= 10));
                chk("mid_busy", busy, 1);
            end
            if (j >= 13) begin
                chk("mid_busy_rel", busy, (j < 19));
                chk("mid_d_out", d_out, (j < 20));
                chk("mid_e_low", e_out, 0);
            end
            if (j == 8) begin
                mode_transparent = 1'b1;
                d_raw = 1'b0;
            end
            if (j == 12) e_raw = 1'b0;
        end
        mode_transparent = 1'b0;
        d_raw = 1'b1;
        repeat (8) step();

        // asynchronous reset mid-pulse
        q.push_back('{1'b1, 8'd4});
        e_raw = 1'b1;
        repeat (8) step();
        chk("ar_pre_e_out", e_out, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_e_out", e_out, 0);
        chk("ar_d_out", d_out, 0);
        chk("ar_busy", busy, 0);
        chk("ar_count", strobe_count, 0);
        step();
        e_raw = 1'b0;
        step();
        rst = 1'b0;
        repeat (10) step();

        // saturation of the strobe counter
        for (int i = 1; i <= 256; i++) begin
            q.push_back('{1'b1, (i >= 255) ? 8'd255 : 8'(i)});
            press_release();
            if (i == 254) chk("sat_254", strobe_count, 254);
            if (i == 255) chk("sat_255", strobe_count, 255);
        end
        chk("sat_256", strobe_count, 255);
        chk("sb_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
